// File: rtl/traffic_pkg.sv
// Shared types and helpers for the multi-approach traffic light controller.
//   phase_e   : encoded controller phase (also driven on the phase output)
//   phase_t   : raw 2-bit phase vector
//   dir_width : width of an approach index for a given approach count
package traffic_pkg;

  typedef logic [1:0] phase_t;

  typedef enum logic [1:0] {
    PH_ALLRED = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2,
    PH_EMG    = 2'd3
  } phase_e;

  // A single-bit index is kept even for one or two approaches so ports never collapse.
  function automatic int dir_width(input int num_dir);
    return (num_dir <= 2) ? 1 : $clog2(num_dir);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase down-counter.
//   clk, rst  : clock, asynchronous active-low reset (count returns to RST_VAL)
//   load      : load load_val this edge (takes priority over counting)
//   load_val  : phase length minus one
//   en        : count enable; the counter stops at zero
//   expired   : count is zero while enabled, i.e. the final cycle of the phase
module phase_timer #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expired = en && (count == '0);

endmodule

// File: rtl/traffic_light_ctrl_multi.sv
// Round-robin traffic light controller for NUM_DIR approaches with pedestrian
// green extension, emergency preemption and a global advance enable.
//   clk, rst        : clock, asynchronous active-low reset
//   en              : advance enable; low freezes phase, timer and lamps
//   ped_req         : pedestrian request pulses, one per approach (latched)
//   emg_req/emg_dir : level-sensitive emergency request and approach to serve
//   red/yellow/green/walk : registered lamp drives per approach
//   cur_dir         : approach owning the current phase
//   phase           : current FSM state (0 ALL_RED, 1 GREEN, 2 YELLOW, 3 EMG)
module traffic_light_ctrl_multi
  import traffic_pkg::*;
#(
  parameter int NUM_DIR     = 4,
  parameter int CNT_W       = 8,
  parameter int GREEN_CYC   = 10,
  parameter int YELLOW_CYC  = 3,
  parameter int ALLRED_CYC  = 2,
  parameter int PED_EXT_CYC = 5,
  localparam int DIR_W      = dir_width(NUM_DIR)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_DIR-1:0] ped_req,
  input  logic               emg_req,
  input  logic [DIR_W-1:0]   emg_dir,
  output logic [NUM_DIR-1:0] red,
  output logic [NUM_DIR-1:0] yellow,
  output logic [NUM_DIR-1:0] green,
  output logic [NUM_DIR-1:0] walk,
  output logic [DIR_W-1:0]   cur_dir,
  output phase_t             phase
);

  localparam logic [CNT_W-1:0] GREEN_LD     = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] GREEN_PED_LD = CNT_W'(GREEN_CYC + PED_EXT_CYC - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD    = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD    = CNT_W'(ALLRED_CYC - 1);

  function automatic logic [NUM_DIR-1:0] dir_oh(input logic [DIR_W-1:0] d);
    return NUM_DIR'(1) << d;
  endfunction

  phase_e             ph_q, ph_d;
  logic [DIR_W-1:0]   dir_q, dir_d, dir_inc;
  logic               first_q, first_d;
  logic [NUM_DIR-1:0] pend_q, pend_clr;
  logic [NUM_DIR-1:0] walk_q, walk_d;
  logic [NUM_DIR-1:0] red_q, yellow_q, green_q;
  logic [NUM_DIR-1:0] red_d, yellow_d, green_d, lamp_oh, grant_oh;
  logic               tmr_load, tmr_en, tmr_exp;
  logic [CNT_W-1:0]   tmr_val;
  logic [31:0]        emg_dir_ext;
  logic               emg_ok;

  // Out-of-range emergency approaches are ignored entirely.
  assign emg_dir_ext = 32'(emg_dir);
  assign emg_ok      = emg_req && (emg_dir_ext < 32'(NUM_DIR));
  assign dir_inc     = (dir_q == DIR_W'(NUM_DIR - 1)) ? '0 : dir_q + DIR_W'(1);
  // The timer sits idle while an emergency green is held.
  assign tmr_en      = en && (ph_q != PH_EMG);

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (ALLRED_LD)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .expired  (tmr_exp)
  );

  always_comb begin
    ph_d     = ph_q;
    dir_d    = dir_q;
    first_d  = first_q;
    walk_d   = walk_q;
    pend_clr = '0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    grant_oh = '0;
    if (en) begin
      case (ph_q)
        PH_ALLRED: begin
          if (tmr_exp) begin
            first_d = 1'b0;
            if (emg_ok) begin
              ph_d   = PH_EMG;
              dir_d  = emg_dir;
              walk_d = '0;
            end else begin
              // After EMG cur_dir already holds the emergency approach, so
              // the plain increment resumes from emg_dir+1.
              ph_d     = PH_GREEN;
              dir_d    = first_q ? '0 : dir_inc;
              grant_oh = dir_oh(dir_d);
              tmr_load = 1'b1;
              if (|(pend_q & grant_oh)) begin
                tmr_val  = GREEN_PED_LD;
                walk_d   = grant_oh;
                pend_clr = grant_oh;
              end else begin
                tmr_val  = GREEN_LD;
                walk_d   = '0;
              end
            end
          end
        end
        PH_GREEN: begin
          if (emg_ok && (emg_dir == dir_q)) begin
            ph_d   = PH_EMG;
            walk_d = '0;
          end else if (emg_ok || tmr_exp) begin
            ph_d     = PH_YELLOW;
            walk_d   = '0;
            tmr_load = 1'b1;
            tmr_val  = YELLOW_LD;
          end
        end
        PH_YELLOW: begin
          if (tmr_exp) begin
            ph_d     = PH_ALLRED;
            tmr_load = 1'b1;
            tmr_val  = ALLRED_LD;
          end
        end
        PH_EMG: begin
          if (!emg_ok) begin
            ph_d     = PH_YELLOW;
            tmr_load = 1'b1;
            tmr_val  = YELLOW_LD;
          end
        end
      endcase
    end
    // Lamps are decoded from the next state so they register on the same edge as phase.
    lamp_oh  = dir_oh(dir_d);
    green_d  = ((ph_d == PH_GREEN) || (ph_d == PH_EMG)) ? lamp_oh : '0;
    yellow_d = (ph_d == PH_YELLOW) ? lamp_oh : '0;
    red_d    = ~(green_d | yellow_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph_q     <= PH_ALLRED;
      dir_q    <= '0;
      first_q  <= 1'b1;
      pend_q   <= '0;
      walk_q   <= '0;
      red_q    <= '1;
      yellow_q <= '0;
      green_q  <= '0;
    end else begin
      ph_q     <= ph_d;
      dir_q    <= dir_d;
      first_q  <= first_d;
      // Set wins over clear; latches track requests even while en is low.
      pend_q   <= (pend_q & ~pend_clr) | ped_req;
      walk_q   <= walk_d;
      red_q    <= red_d;
      yellow_q <= yellow_d;
      green_q  <= green_d;
    end
  end

  assign red     = red_q;
  assign yellow  = yellow_q;
  assign green   = green_q;
  assign walk    = walk_q;
  assign cur_dir = dir_q;
  assign phase   = phase_t'(ph_q);

endmodule
